// File: rtl/pc_ctrl_if.sv
// Bundle of hazard-side inputs and PC/pipeline-side outputs of the fetch sequencer.
// The master drives the hazard inputs; the slave (pc_ctrl) drives the strobes.
interface pc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             br_taken_ex;
    logic [31:0]      br_target_ex;
    logic             jmp_id;
    logic [31:0]      jmp_target_id;
    logic             load_use_id;
    logic             halt_req_ex;
    logic             resume;
    logic             pc_bj;
    logic [31:0]      pc_src;
    logic             nop_lock_id;
    logic             flush_id;
    logic             flush_ex;
    logic             halt;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output br_taken_ex, br_target_ex, jmp_id, jmp_target_id, load_use_id,
               halt_req_ex, resume,
        input  pc_bj, pc_src, nop_lock_id, flush_id, flush_ex, halt, state,
               stall_count, flush_count
    );

    modport slave (
        input  br_taken_ex, br_target_ex, jmp_id, jmp_target_id, load_use_id,
               halt_req_ex, resume,
        output pc_bj, pc_src, nop_lock_id, flush_id, flush_ex, halt, state,
               stall_count, flush_count
    );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch sequencer: picks redirect / load-use bubble / halt drain for the PC each cycle.
// Optional performance counters are enabled with the PC_CTRL_PERF_EN macro; without it
// stall_count and flush_count are tied to zero.
module pc_ctrl #(
    parameter int unsigned DRAIN_DEPTH = 3,
    parameter int unsigned CNT_W       = 32
) (
    input logic  clk,
    input logic  rst,
    pc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StStall  = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } state_e;

    localparam logic [3:0] DrainLoad = 4'(DRAIN_DEPTH - 1);

    state_e      state_q;
    logic        halt_q;
    logic [3:0]  drain_q;

    logic        pc_bj;
    logic [31:0] pc_src;
    logic        nop_lock_id;
    logic        flush_id;
    logic        flush_ex;
    logic        go_stall;
    logic        go_drain;

    // Same-cycle strobes from current state and hazard inputs; all forced low in reset.
    always_comb begin
        pc_bj       = 1'b0;
        pc_src      = 32'h0;
        nop_lock_id = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        go_stall    = 1'b0;
        go_drain    = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun, StStall: begin
                    if (bus.halt_req_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                        go_drain = 1'b1;
                    end else if (bus.br_taken_ex) begin
                        pc_bj    = 1'b1;
                        pc_src   = bus.br_target_ex;
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (bus.jmp_id) begin
                        pc_bj    = 1'b1;
                        pc_src   = bus.jmp_target_id;
                        flush_id = 1'b1;
                    end else if (bus.load_use_id && (state_q == StRun)) begin
                        // In StStall the hazard still refers to the load already bubbled.
                        nop_lock_id = 1'b1;
                        flush_ex    = 1'b1;
                        go_stall    = 1'b1;
                    end
                end
                StDrain: begin
                    nop_lock_id = 1'b1;
                    flush_id    = 1'b1;
                end
                StHalted: begin
                    nop_lock_id = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State register, drain countdown and registered halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            halt_q  <= 1'b0;
            drain_q <= 4'd0;
        end else begin
            case (state_q)
                StRun, StStall: begin
                    if (go_drain) begin
                        state_q <= StDrain;
                        drain_q <= DrainLoad;
                    end else if (go_stall) begin
                        state_q <= StStall;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StDrain: begin
                    if (drain_q == 4'd0) begin
                        state_q <= StHalted;
                        halt_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 4'd1;
                    end
                end
                StHalted: begin
                    if (bus.resume) begin
                        state_q <= StRun;
                        halt_q  <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef PC_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Bubble and redirect counters, wrapping naturally at CNT_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (go_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (pc_bj)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.stall_count = {CNT_W{1'b0}};
    assign bus.flush_count = {CNT_W{1'b0}};
`endif

    assign bus.pc_bj       = pc_bj;
    assign bus.pc_src      = pc_src;
    assign bus.nop_lock_id = nop_lock_id;
    assign bus.flush_id    = flush_id;
    assign bus.flush_ex    = flush_ex;
    assign bus.halt        = halt_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table plus randomized run against
// a cycle-level behavioural model.
module tb_pc_ctrl;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = 32;

    logic clk;
    logic rst;
    pc_ctrl_if #(.CNT_W(CW)) bus ();

    pc_ctrl #(.DRAIN_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        lu;
        logic        hr;
        logic        res;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        bj;
        logic [31:0] src;
        logic        nop;
        logic        fid;
        logic        fex;
        logic [1:0]  st;
        logic        hlt;
    } vec_t;

    int checks;
    int failures;

    // Model: remaining drain cycles, halted flag, "last cycle was a bubble" flag.
    int          m_drain;
    bit          m_halted;
    bit          m_stall;
    logic [31:0] m_sc;
    logic [31:0] m_fc;
    logic        e_bj, e_nop, e_fid, e_fex;
    logic [31:0] e_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_halted) return 2'd3;
        if (m_drain > 0) return 2'd2;
        if (m_stall) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_comb(input stim_t s);
        e_bj = 0; e_src = 0; e_nop = 0; e_fid = 0; e_fex = 0;
        if (s.rst) begin
        end else if (m_halted) begin
            e_nop = 1;
        end else if (m_drain > 0) begin
            e_nop = 1; e_fid = 1;
        end else if (s.hr) begin
            e_fid = 1; e_fex = 1;
        end else if (s.br) begin
            e_bj = 1; e_src = s.bt; e_fid = 1; e_fex = 1;
        end else if (s.jmp) begin
            e_bj = 1; e_src = s.jt; e_fid = 1;
        end else if (s.lu && !m_stall) begin
            e_nop = 1; e_fex = 1;
        end
    endtask

    task automatic model_edge(input stim_t s);
        if (s.rst) begin
            m_drain = 0; m_halted = 0; m_stall = 0; m_sc = 0; m_fc = 0;
        end else if (m_halted) begin
            if (s.res) m_halted = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1;
        end else begin
            if (e_bj) m_fc = m_fc + 1;
            if (s.hr) begin
                m_drain = DEPTH;
                m_stall = 0;
            end else if (!s.br && !s.jmp && s.lu && !m_stall) begin
                m_stall = 1;
                m_sc    = m_sc + 1;
            end else begin
                m_stall = 0;
            end
        end
    endtask

    // Drive one cycle of stimulus, check strobes mid-cycle and registers after the edge.
    task automatic apply(input stim_t s, output logic [35:0] comb);
        logic [31:0] exp_sc, exp_fc;
        rst               = s.rst;
        bus.br_taken_ex   = s.br;
        bus.br_target_ex  = s.bt;
        bus.jmp_id        = s.jmp;
        bus.jmp_target_id = s.jt;
        bus.load_use_id   = s.lu;
        bus.halt_req_ex   = s.hr;
        bus.resume        = s.res;
        #1;
        model_comb(s);
        chk("m_pc_bj", 32'(bus.pc_bj), 32'(e_bj));
        chk("m_pc_src", bus.pc_src, e_src);
        chk("m_nop_lock_id", 32'(bus.nop_lock_id), 32'(e_nop));
        chk("m_flush_id", 32'(bus.flush_id), 32'(e_fid));
        chk("m_flush_ex", 32'(bus.flush_ex), 32'(e_fex));
        comb = {bus.pc_bj, bus.nop_lock_id, bus.flush_id, bus.flush_ex, bus.pc_src};
        @(posedge clk);
        model_edge(s);
        #1;
`ifdef PC_CTRL_PERF_EN
        exp_sc = m_sc;
        exp_fc = m_fc;
`else
        exp_sc = 32'h0;
        exp_fc = 32'h0;
`endif
        chk("m_state", 32'(bus.state), 32'(m_state()));
        chk("m_halt", 32'(bus.halt), 32'(m_halted));
        chk("m_stall_count", bus.stall_count, exp_sc);
        chk("m_flush_count", bus.flush_count, exp_fc);
    endtask

    function automatic vec_t row(input logic r, input logic b, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic lu,
                                 input logic hr, input logic res, input logic bj,
                                 input logic [31:0] src, input logic nop, input logic fid,
                                 input logic fex, input logic [1:0] st, input logic hlt);
        vec_t v;
        v.s   = '{rst: r, br: b, bt: bt, jmp: j, jt: jt, lu: lu, hr: hr, res: res};
        v.bj  = bj; v.src = src; v.nop = nop; v.fid = fid; v.fex = fex;
        v.st  = st; v.hlt = hlt;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        logic [35:0] comb;
        stim_t       s;
        checks   = 0;
        failures = 0;
        m_drain  = 0; m_halted = 0; m_stall = 0; m_sc = 0; m_fc = 0;

        //             rst br bt     jmp jt     lu hr res  bj src    nop fid fex st hlt
        tbl[0]  = row(1, 1, 32'h40, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[1]  = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[2]  = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 1,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[3]  = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[4]  = row(0, 1, 32'h40, 1, 32'h80, 0, 0, 0,   1, 32'h40, 0, 1, 1, 0, 0);
        tbl[5]  = row(0, 0, 32'h0,  1, 32'h80, 0, 0, 0,   1, 32'h80, 0, 1, 0, 0, 0);
        tbl[6]  = row(0, 0, 32'h0,  0, 32'h0,  1, 0, 0,   0, 32'h0,  1, 0, 1, 1, 0);
        tbl[7]  = row(0, 0, 32'h0,  0, 32'h0,  1, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[8]  = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[9]  = row(0, 0, 32'h0,  0, 32'h0,  0, 1, 0,   0, 32'h0,  0, 1, 1, 2, 0);
        tbl[10] = row(0, 1, 32'h40, 0, 32'h0,  0, 0, 0,   0, 32'h0,  1, 1, 0, 2, 0);
        tbl[11] = row(0, 0, 32'h0,  0, 32'h0,  1, 0, 1,   0, 32'h0,  1, 1, 0, 2, 0);
        tbl[12] = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  1, 1, 0, 3, 1);
        tbl[13] = row(0, 1, 32'h50, 0, 32'h0,  0, 0, 0,   0, 32'h0,  1, 0, 0, 3, 1);
        tbl[14] = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 1,   0, 32'h0,  1, 0, 0, 0, 0);
        tbl[15] = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 1,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[16] = row(0, 1, 32'h44, 0, 32'h0,  1, 0, 0,   1, 32'h44, 0, 1, 1, 0, 0);
        tbl[17] = row(0, 0, 32'h0,  0, 32'h0,  1, 0, 0,   0, 32'h0,  1, 0, 1, 1, 0);
        tbl[18] = row(0, 1, 32'h48, 0, 32'h0,  1, 0, 0,   1, 32'h48, 0, 1, 1, 0, 0);
        tbl[19] = row(0, 0, 32'h0,  0, 32'h0,  1, 0, 0,   0, 32'h0,  1, 0, 1, 1, 0);
        tbl[20] = row(0, 1, 32'h4c, 0, 32'h0,  1, 1, 0,   0, 32'h0,  0, 1, 1, 2, 0);
        tbl[21] = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  1, 1, 0, 2, 0);
        tbl[22] = row(1, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);
        tbl[23] = row(0, 0, 32'h0,  0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].s, comb);
            chk($sformatf("tbl%0d_pc_bj", i), 32'(comb[35]), 32'(tbl[i].bj));
            chk($sformatf("tbl%0d_nop_lock_id", i), 32'(comb[34]), 32'(tbl[i].nop));
            chk($sformatf("tbl%0d_flush_id", i), 32'(comb[33]), 32'(tbl[i].fid));
            chk($sformatf("tbl%0d_flush_ex", i), 32'(comb[32]), 32'(tbl[i].fex));
            chk($sformatf("tbl%0d_pc_src", i), comb[31:0], tbl[i].src);
            chk($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_halt", i), 32'(bus.halt), 32'(tbl[i].hlt));
        end

        // Idle run after reset: strobes stay quiet for ten cycles.
        s = '0;
        for (int i = 0; i < 10; i++) begin
            apply(s, comb);
            chk("idle_strobes", 32'(comb[35:32]), 32'h0);
        end

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 99) == 0);
            s.br  = ($urandom_range(0, 7) == 0);
            s.bt  = $urandom;
            s.jmp = ($urandom_range(0, 7) == 0);
            s.jt  = $urandom;
            s.lu  = ($urandom_range(0, 3) == 0);
            s.hr  = ($urandom_range(0, 39) == 0);
            s.res = ($urandom_range(0, 3) == 0);
            apply(s, comb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
